// File: rtl/btc_pkg.sv
// -----------------------------------------------------------------------------
// btc_pkg
// Shared constants, the delay-line stage record and a lane-extraction helper
// for the tensor-core result collector.
// -----------------------------------------------------------------------------
package btc_pkg;

  localparam int LANES      = 16;              // accumulator lanes per result
  localparam int ACC_W      = 32;              // signed accumulator lane width
  localparam int OUT_W      = 8;               // signed requantized lane width
  localparam int LAT        = 2;               // issue-to-result latency of the array
  localparam int PACK       = 4;               // results packed per output word
  localparam int FIFO_DEPTH = 4;               // output word FIFO entries
  localparam int SHIFT_W    = 5;               // rounding shift amount width
  localparam int SAT_W      = 16;              // saturation counter width

  localparam int BUS_W  = LANES * ACC_W;       // result bus width
  localparam int SLOT_W = LANES * OUT_W;       // one requantized result
  localparam int WORD_W = PACK * SLOT_W;       // packed writeback word

  // One delay-line stage: what the issuer told us about the tile in flight.
  typedef struct packed {
    logic               valid;
    logic               last;
    logic [SHIFT_W-1:0] shift;
    logic               relu;
  } stage_t;

  // Lane idx of the result bus, as a signed accumulator value.
  function automatic logic signed [ACC_W-1:0] lane_acc(
    input logic [BUS_W-1:0] bus,
    input int unsigned      idx
  );
    return bus[idx*ACC_W +: ACC_W];
  endfunction

endpackage

// File: rtl/btc_result_collector_if.sv
// -----------------------------------------------------------------------------
// btc_result_collector_if
// Issue sideband, result bus, writeback port and status of the collector.
//   master : issuer / array / consumer side (drives issue_*, result_in, out_ready)
//   slave  : collector side (drives credit_ok, out_*, sat_count, err_overrun)
// -----------------------------------------------------------------------------
interface btc_result_collector_if;
  import btc_pkg::*;

  logic               issue_valid;
  logic               issue_last;
  logic [SHIFT_W-1:0] issue_shift;
  logic               issue_relu;
  logic [BUS_W-1:0]   result_in;
  logic               credit_ok;
  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  out_data;
  logic               out_last;
  logic [SAT_W-1:0]   sat_count;
  logic               err_overrun;

  modport master (
    output issue_valid, issue_last, issue_shift, issue_relu, result_in, out_ready,
    input  credit_ok, out_valid, out_data, out_last, sat_count, err_overrun
  );

  modport slave (
    input  issue_valid, issue_last, issue_shift, issue_relu, result_in, out_ready,
    output credit_ok, out_valid, out_data, out_last, sat_count, err_overrun
  );

endinterface

// File: rtl/btc_word_fifo.sv
// -----------------------------------------------------------------------------
// btc_word_fifo
// Synchronous FIFO with registered storage. Simultaneous push and pop are
// allowed (a push into a full FIFO is accepted only if a pop happens on the
// same edge, otherwise it is dropped). rdata reads 0 while empty.
//   clk, rst_n       : clock, asynchronous active-low reset
//   push, wdata      : write request and data
//   pop, rdata       : read request and head data
//   full, empty      : status flags
//   count            : number of stored entries
// -----------------------------------------------------------------------------
module btc_word_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign count     = count_r;
  assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/btc_result_collector.sv
// -----------------------------------------------------------------------------
// btc_result_collector
// Consumes the tensor-core array result bus, requantizes each result to int8
// (optional ReLU, round-half-up shift, saturation), packs PACK results per
// writeback word and buffers words in a FIFO behind a valid/ready port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.issue_*    : per-issue sideband (valid, last, shift, relu)
//   bus.result_in  : array result, valid LAT cycles after its issue
//   bus.credit_ok  : issuer may start a new tile this cycle
//   bus.out_*      : packed word stream (valid/ready, data, last)
//   bus.sat_count  : saturated lanes since reset (sticks at max)
//   bus.err_overrun: sticky; issue without credit, or a word was dropped
// -----------------------------------------------------------------------------
module btc_result_collector
  import btc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  btc_result_collector_if.slave bus
);

  localparam int IDX_W     = $clog2(PACK);
  localparam int SAT_INC_W = $clog2(LANES + 1);
  localparam int DLY_CNT_W = $clog2(LAT + 1);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int RES_W     = CNT_W + 1;
  localparam int ENTRY_W   = WORD_W + 1;

  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W + 1)'((32'sd1 <<< (OUT_W - 1)) - 32'sd1);
  localparam logic signed [ACC_W:0] Q_MIN = (ACC_W + 1)'(-(32'sd1 <<< (OUT_W - 1)));

  // Requantize one lane; returns {saturated, int8 value}. The extra bit of
  // headroom keeps value + rounding constant from wrapping.
  function automatic logic [OUT_W:0] requant(
    input logic signed [ACC_W-1:0] acc,
    input logic [SHIFT_W-1:0]      shift,
    input logic                    relu
  );
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] half;
    logic [OUT_W:0]        res;
    if (relu && acc[ACC_W-1]) begin
      wide = {(ACC_W + 1){1'b0}};
    end else begin
      wide = {acc[ACC_W-1], acc};
    end
    if (shift != {SHIFT_W{1'b0}}) begin
      half = $signed({{ACC_W{1'b0}}, 1'b1}) <<< (shift - SHIFT_W'(1));
      wide = (wide + half) >>> shift;
    end else begin
      half = {(ACC_W + 1){1'b0}};
    end
    if (wide > Q_MAX) begin
      res = {1'b1, Q_MAX[OUT_W-1:0]};
    end else if (wide < Q_MIN) begin
      res = {1'b1, Q_MIN[OUT_W-1:0]};
    end else begin
      res = {1'b0, wide[OUT_W-1:0]};
    end
    return res;
  endfunction

  stage_t               dly_r [LAT];
  stage_t               head_s;
  logic [SLOT_W-1:0]    slot_s;
  logic [LANES-1:0]     lane_sat_s;
  logic [SAT_INC_W-1:0] sat_inc_s;
  logic [SAT_W:0]       sat_sum_s;
  logic [WORD_W-1:0]    pack_r;
  logic [WORD_W-1:0]    word_s;
  logic [IDX_W-1:0]     pack_idx_r;
  logic                 flush_s;
  logic                 pop_s;
  logic                 drop_s;
  logic [SAT_W-1:0]     sat_count_r;
  logic                 err_overrun_r;
  logic [ENTRY_W-1:0]   head_entry_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [CNT_W-1:0]     fifo_count_s;
  logic [DLY_CNT_W-1:0] dly_cnt_s;
  logic [RES_W-1:0]     reserved_s;
  logic                 credit_s;

  // The last stage lines up with the cycle the array presents that tile's result.
  assign head_s = dly_r[LAT-1];

  // Issue-aligned delay line; idle cycles travel through as bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        dly_r[i] <= {$bits(stage_t){1'b0}};
      end
    end else begin
      dly_r[0] <= '{valid: bus.issue_valid, last: bus.issue_last,
                    shift: bus.issue_shift, relu: bus.issue_relu};
      for (int i = 1; i < LAT; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [OUT_W:0] rq_s;
    assign rq_s = requant(lane_acc(bus.result_in, g), head_s.shift, head_s.relu);
    assign slot_s[g*OUT_W +: OUT_W] = rq_s[OUT_W-1:0];
    assign lane_sat_s[g]            = rq_s[OUT_W];
  end

  // Count clipped lanes of the current result.
  always_comb begin
    sat_inc_s = {SAT_INC_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      sat_inc_s = sat_inc_s + SAT_INC_W'(lane_sat_s[i]);
    end
  end

  // Count tiles still in flight; each will need one FIFO entry in the worst case.
  always_comb begin
    dly_cnt_s = {DLY_CNT_W{1'b0}};
    for (int i = 0; i < LAT; i++) begin
      dly_cnt_s = dly_cnt_s + DLY_CNT_W'(dly_r[i].valid);
    end
  end

  // Drop the new result into its slot and decide whether this word closes.
  always_comb begin
    word_s = pack_r;
    word_s[pack_idx_r*SLOT_W +: SLOT_W] = slot_s;
    if (head_s.valid && ((pack_idx_r == IDX_W'(PACK - 1)) || head_s.last)) begin
      flush_s = 1'b1;
    end else begin
      flush_s = 1'b0;
    end
  end

  // Pack register and slot index; a closed word restarts from an all-zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_r     <= {WORD_W{1'b0}};
      pack_idx_r <= {IDX_W{1'b0}};
    end else if (flush_s) begin
      pack_r     <= {WORD_W{1'b0}};
      pack_idx_r <= {IDX_W{1'b0}};
    end else if (head_s.valid) begin
      pack_r     <= word_s;
      pack_idx_r <= pack_idx_r + IDX_W'(1);
    end
  end

  assign sat_sum_s = {1'b0, sat_count_r} + (SAT_W + 1)'(sat_inc_s);

  // Saturation counter, pinned at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_r <= {SAT_W{1'b0}};
    end else if (head_s.valid) begin
      sat_count_r <= sat_sum_s[SAT_W] ? {SAT_W{1'b1}} : sat_sum_s[SAT_W-1:0];
    end
  end

  assign pop_s      = !fifo_empty_s && bus.out_ready;
  assign drop_s     = flush_s && fifo_full_s && !pop_s;
  assign reserved_s = RES_W'(fifo_count_s) + RES_W'(dly_cnt_s);
  assign credit_s   = (reserved_s < RES_W'(FIFO_DEPTH));

  // Sticky overrun flag: issue without credit, or a closed word had nowhere to go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun_r <= 1'b0;
    end else if ((bus.issue_valid && !credit_s) || drop_s) begin
      err_overrun_r <= 1'b1;
    end
  end

  btc_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (flush_s),
    .wdata ({head_s.last, word_s}),
    .pop   (pop_s),
    .rdata (head_entry_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign bus.out_valid   = !fifo_empty_s;
  assign bus.out_data    = head_entry_s[WORD_W-1:0];
  assign bus.out_last    = head_entry_s[WORD_W];
  assign bus.credit_ok   = credit_s;
  assign bus.sat_count   = sat_count_r;
  assign bus.err_overrun = err_overrun_r;

endmodule

// File: tb/tb_btc_result_collector.sv
// -----------------------------------------------------------------------------
// tb_btc_result_collector
// Random and directed stimulus against a queue-based reference model of the
// collector (in-flight tile queue, pack slots, output word queue).
// -----------------------------------------------------------------------------
module tb_btc_result_collector;
  import btc_pkg::*;

  logic clk;
  logic rst_n;

  btc_result_collector_if bus ();

  btc_result_collector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int unsigned  due;
    bit           last;
    logic [4:0]   shift;
    bit           relu;
    logic [511:0] data;
  } tile_t;

  tile_t        inflight_q[$];
  logic [512:0] fifo_q[$];
  logic [511:0] m_pack;
  int           m_idx;
  int           m_sat;
  bit           m_err;
  int unsigned  cyc;
  int           checks;
  int           errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [511:0] splat(input int v);
    logic [511:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  // Lane values biased toward the clip boundaries for the given shift.
  function automatic logic [511:0] rand_tile(input int sh);
    logic [511:0] r;
    int v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 600)) - 300;
        1:       v = int'($urandom());
        2:       v = (127 << sh) + int'($urandom_range(0, 3)) * (1 << sh) / 2 - (1 << sh);
        default: v = -(128 << sh) + int'($urandom_range(0, 3)) * (1 << sh) / 2 - (1 << sh);
      endcase
      r[i*32 +: 32] = v;
    end
    return r;
  endfunction

  // Reference requantization: plain integer arithmetic on a 64-bit value.
  function automatic logic [7:0] ref_q(input int acc, input int sh, input bit relu, output bit sat);
    longint v;
    v = acc;
    if (relu && v < 0) v = 0;
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    sat = 1'b0;
    if (v > 127) begin
      v = 127;
      sat = 1'b1;
    end else if (v < -128) begin
      v = -128;
      sat = 1'b1;
    end
    return v[7:0];
  endfunction

  function automatic bit m_credit();
    return (fifo_q.size() + inflight_q.size()) < FIFO_DEPTH;
  endfunction

  task automatic model_clear();
    inflight_q.delete();
    fifo_q.delete();
    m_pack = '0;
    m_idx  = 0;
    m_sat  = 0;
    m_err  = 1'b0;
  endtask

  // Effect of one clock edge on the model, given this cycle's inputs.
  task automatic model_edge(input bit iv, input bit il, input logic [4:0] sh, input bit rl,
                            input logic [511:0] d, input bit rdy);
    bit         pop_now;
    bit         s;
    logic [7:0] q;
    int         a;
    tile_t      t;
    tile_t      n;
    pop_now = (fifo_q.size() > 0) && rdy;
    if (iv && !m_credit()) m_err = 1'b1;
    if (pop_now) void'(fifo_q.pop_front());
    if (inflight_q.size() > 0 && inflight_q[0].due == cyc) begin
      t = inflight_q.pop_front();
      for (int l = 0; l < LANES; l++) begin
        a = t.data[l*32 +: 32];
        q = ref_q(a, int'(t.shift), t.relu, s);
        m_pack[m_idx*128 + l*8 +: 8] = q;
        if (s) m_sat = (m_sat < 65535) ? m_sat + 1 : 65535;
      end
      if (m_idx == PACK - 1 || t.last) begin
        if (fifo_q.size() < FIFO_DEPTH) fifo_q.push_back({t.last, m_pack});
        else m_err = 1'b1;
        m_pack = '0;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
    if (iv) begin
      n.due   = cyc + LAT;
      n.last  = il;
      n.shift = sh;
      n.relu  = rl;
      n.data  = d;
      inflight_q.push_back(n);
    end
  endtask

  task automatic compare_outputs();
    logic [512:0] h;
    h = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    check_eq("out_valid",   512'(bus.out_valid),   512'(fifo_q.size() > 0));
    check_eq("out_data",    bus.out_data,          h[511:0]);
    check_eq("out_last",    512'(bus.out_last),    512'(h[512]));
    check_eq("credit_ok",   512'(bus.credit_ok),   512'(m_credit()));
    check_eq("sat_count",   512'(bus.sat_count),   512'(m_sat));
    check_eq("err_overrun", 512'(bus.err_overrun), 512'(m_err));
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic cycle(input bit iv, input bit il, input logic [4:0] sh, input bit rl,
                       input logic [511:0] d, input bit rdy);
    bus.issue_valid = iv;
    bus.issue_last  = il;
    bus.issue_shift = sh;
    bus.issue_relu  = rl;
    bus.out_ready   = rdy;
    if (inflight_q.size() > 0 && inflight_q[0].due == cyc) bus.result_in = inflight_q[0].data;
    else bus.result_in = rand512();
    model_edge(iv, il, sh, rl, d, rdy);
    @(posedge clk);
    #1;
    cyc++;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0, '0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_last  = 1'b0;
    bus.issue_shift = 5'd0;
    bus.issue_relu  = 1'b0;
    bus.out_ready   = 1'b0;
    bus.result_in   = '0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [511:0] exp_w;
    int           issued;
    bit           iv;
    logic [4:0]   sh;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    model_clear();
    do_reset();

    // Pack: four results 1..4, last on the fourth, held by out_ready=0.
    for (int k = 0; k < 4; k++) cycle(1'b1, k == 3, 5'd0, 1'b0, splat(k + 1), 1'b0);
    idle(2, 1'b0);
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < LANES; l++) exp_w[k*128 + l*8 +: 8] = 8'(k + 1);
    check_eq("pack_word", bus.out_data, exp_w);
    check_eq("pack_last", 512'(bus.out_last), 512'(1'b1));
    idle(2, 1'b1);

    // Flush with ReLU: -5 clamps to 0, remaining slots stay 0.
    cycle(1'b1, 1'b1, 5'd0, 1'b1, splat(-5), 1'b0);
    idle(2, 1'b0);
    check_eq("flush_valid", 512'(bus.out_valid), 512'(1'b1));
    check_eq("flush_word",  bus.out_data, 512'(0));
    check_eq("flush_last",  512'(bus.out_last), 512'(1'b1));
    idle(2, 1'b1);

    // Rounding and saturation with shift=4.
    exp_w = '0;
    exp_w[0*32 +: 32] = 32'd24;
    exp_w[1*32 +: 32] = 32'd23;
    exp_w[2*32 +: 32] = -32'sd24;
    exp_w[3*32 +: 32] = 32'd5000;
    exp_w[4*32 +: 32] = -32'sd5000;
    cycle(1'b1, 1'b1, 5'd4, 1'b0, exp_w, 1'b0);
    idle(2, 1'b0);
    check_eq("round_slot0", 512'(bus.out_data[127:0]), 512'({88'h0, 8'h80, 8'h7F, 8'hFF, 8'h01, 8'h02}));
    check_eq("round_sat",   512'(bus.sat_count), 512'(2));
    idle(3, 1'b1);

    // Backpressure: issue only on credit, consumer stalled.
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      iv = bus.credit_ok;
      if (iv) issued++;
      cycle(iv, 1'b1, 5'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), rand_tile(4), 1'b0);
    end
    check_eq("bp_issued", 512'(issued), 512'(4));
    check_eq("bp_credit", 512'(bus.credit_ok), 512'(1'b0));
    check_eq("bp_err",    512'(bus.err_overrun), 512'(1'b0));
    idle(6, 1'b1);

    // Random traffic with credit-respecting issuer.
    for (int i = 0; i < 1500; i++) begin
      iv = bus.credit_ok && ($urandom_range(0, 3) != 0);
      sh = 5'($urandom_range(0, 31));
      cycle(iv, $urandom_range(0, 3) == 0, sh, 1'($urandom_range(0, 1)),
            rand_tile(int'(sh) > 20 ? 4 : int'(sh)), 1'($urandom_range(0, 2) != 0));
    end
    idle(6, 1'b1);

    // Overrun: issue regardless of credit while stalled.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 5'd0, 1'b0, rand_tile(0), 1'b0);
    check_eq("ovr_err", 512'(bus.err_overrun), 512'(1'b1));
    idle(8, 1'b1);
    check_eq("ovr_sticky", 512'(bus.err_overrun), 512'(1'b1));

    // Reset mid-operation: two words buffered, two tiles in flight.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 5'd0, 1'b0, splat(5000), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 512'(bus.out_valid), 512'(1'b0));
    check_eq("rst_credit",    512'(bus.credit_ok), 512'(1'b1));
    check_eq("rst_sat",       512'(bus.sat_count), 512'(0));
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle(6, 1'b1);

    // Saturation counter pins at its maximum.
    for (int i = 0; i < 4200; i++) begin
      iv = bus.credit_ok;
      cycle(iv, $urandom_range(0, 1) == 0, 5'd0, 1'b0, splat(5000), 1'b1);
    end
    idle(4, 1'b1);
    check_eq("sat_max", 512'(bus.sat_count), 512'(16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
